sad_min_select: RTL and testbench



---
 rtl/sad_min_select.sv | 111 +++++++++++
 tb/tb_sad_min_select.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sad_min_select.sv
// Running-minimum selector over a raster-scanned search window of SAD candidates.
// Emits the best (SAD, x, y) with a one-cycle res_en pulse after the last candidate.
module sad_min_select #(
    parameter int unsigned SAD_W = 14,
    parameter int unsigned CRD_W = 4,
    parameter int unsigned WIN_W = 16,
    parameter int unsigned WIN_H = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad_in,
    output logic             busy,
    output logic             res_en,
    output logic [SAD_W-1:0] best_sad,
    output logic [CRD_W-1:0] best_x,
    output logic [CRD_W-1:0] best_y
);

    localparam logic [CRD_W-1:0] X_LAST = CRD_W'(WIN_W - 1);
    localparam logic [CRD_W-1:0] Y_LAST = CRD_W'(WIN_H - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t             state;
    logic [CRD_W-1:0]   cx;
    logic [CRD_W-1:0]   cy;
    logic               first_flag;
    logic [SAD_W-1:0]   run_sad;
    logic [CRD_W-1:0]   run_x;
    logic [CRD_W-1:0]   run_y;

    logic               accept_c;
    logic               first_c;
    logic               better_c;
    logic               last_c;
    logic [CRD_W-1:0]   pos_x_c;
    logic [CRD_W-1:0]   pos_y_c;
    logic [SAD_W-1:0]   cand_sad_c;
    logic [CRD_W-1:0]   cand_x_c;
    logic [CRD_W-1:0]   cand_y_c;

    // A start cycle behaves as a fresh search at (0,0), so a coincident candidate is its first.
    always_comb begin
        accept_c   = sad_valid && (start || (state == ACC));
        pos_x_c    = start ? '0 : cx;
        pos_y_c    = start ? '0 : cy;
        first_c    = start || first_flag;
        better_c   = first_c || (sad_in < run_sad);
        last_c     = !start && (state == ACC) && (cx == X_LAST) && (cy == Y_LAST);
        cand_sad_c = better_c ? sad_in  : run_sad;
        cand_x_c   = better_c ? pos_x_c : run_x;
        cand_y_c   = better_c ? pos_y_c : run_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            res_en     <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            first_flag <= 1'b0;
            run_sad    <= '0;
            run_x      <= '0;
            run_y      <= '0;
            best_sad   <= '0;
            best_x     <= '0;
            best_y     <= '0;
        end else begin
            res_en <= 1'b0;

            // Start opens a new search and silently drops any search in progress.
            if (start) begin
                state      <= ACC;
                busy       <= 1'b1;
                first_flag <= 1'b1;
                cx         <= '0;
                cy         <= '0;
            end

            if (accept_c) begin
                run_sad    <= cand_sad_c;
                run_x      <= cand_x_c;
                run_y      <= cand_y_c;
                first_flag <= 1'b0;
                if (last_c) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    res_en   <= 1'b1;
                    best_sad <= cand_sad_c;
                    best_x   <= cand_x_c;
                    best_y   <= cand_y_c;
                    cx       <= '0;
                    cy       <= '0;
                end else if (pos_x_c == X_LAST) begin
                    cx <= '0;
                    cy <= pos_y_c + CRD_W'(1);
                end else begin
                    cx <= pos_x_c + CRD_W'(1);
                    cy <= pos_y_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_min_select.sv
// Directed bench for sad_min_select: hand-computed window minima, abort, reset, hold and serializer readout.
module tb_sad_min_select;

    localparam int unsigned SAD_W = 14;
    localparam int unsigned CRD_W = 4;
    localparam int unsigned WIN_W = 16;
    localparam int unsigned WIN_H = 16;
    localparam int          N     = WIN_W * WIN_H;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sad_valid;
    logic [SAD_W-1:0] sad_in;
    logic             busy;
    logic             res_en;
    logic [SAD_W-1:0] best_sad;
    logic [CRD_W-1:0] best_x;
    logic [CRD_W-1:0] best_y;

    sad_min_select #(
        .SAD_W(SAD_W),
        .CRD_W(CRD_W),
        .WIN_W(WIN_W),
        .WIN_H(WIN_H)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sad_valid(sad_valid),
        .sad_in   (sad_in),
        .busy     (busy),
        .res_en   (res_en),
        .best_sad (best_sad),
        .best_x   (best_x),
        .best_y   (best_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int pulses = 0;
    int vals[N];

    logic        hold_on = 1'b0;
    int          hold_sad = 0;
    int          hold_x = 0;
    int          hold_y = 0;

    // Minimal serializer model: loads best_sad on res_en, shifts it out MSB-first.
    logic [SAD_W-1:0] ser_sh = '0;
    int               ser_cnt = 0;
    logic             ser_out;
    assign ser_out = ser_sh[SAD_W-1];

    always @(posedge clk) begin
        if (res_en) begin
            ser_sh  <= best_sad;
            ser_cnt <= SAD_W;
        end else if (ser_cnt > 0) begin
            ser_sh  <= ser_sh << 1;
            ser_cnt <= ser_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (res_en) pulses++;
        if (hold_on && !res_en) begin
            check("hold_sad", 32'(best_sad), 32'(hold_sad));
            check("hold_x", 32'(best_x), 32'(hold_x));
            check("hold_y", 32'(best_y), 32'(hold_y));
        end
    end

    task automatic fill(input int v);
        for (int i = 0; i < N; i++) vals[i] = v;
    endtask

    // Drives start then n candidates; for a full window, checks the pulse in the cycle after the last.
    task automatic run_window(input string tag, input int n, input bit gaps,
                              input int exp_sad, input int exp_x, input int exp_y);
        start     = 1'b1;
        sad_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_open"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                sad_valid = 1'b0;
                repeat (int'($urandom_range(0, 2))) @(negedge clk);
            end
            if (i == N - 1) begin
                check({tag, "_no_early_pulse"}, 32'(res_en), 32'd0);
                check({tag, "_busy_before_last"}, 32'(busy), 32'd1);
            end
            sad_valid = 1'b1;
            sad_in    = SAD_W'(vals[i]);
            @(negedge clk);
        end
        sad_valid = 1'b0;
        if (n == N) begin
            check({tag, "_res_en"}, 32'(res_en), 32'd1);
            check({tag, "_busy_low"}, 32'(busy), 32'd0);
            check({tag, "_sad"}, 32'(best_sad), 32'(exp_sad));
            check({tag, "_x"}, 32'(best_x), 32'(exp_x));
            check({tag, "_y"}, 32'(best_y), 32'(exp_y));
            hold_sad = exp_sad;
            hold_x   = exp_x;
            hold_y   = exp_y;
        end
    endtask

    task automatic expect_pulse_end(input string tag);
        @(negedge clk);
        check({tag, "_pulse_one_cycle"}, 32'(res_en), 32'd0);
    endtask

    initial begin
        int p0;
        logic [SAD_W-1:0] bits;

        rst_n     = 1'b0;
        start     = 1'b0;
        sad_valid = 1'b0;
        sad_in    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_res_en", 32'(res_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sad", 32'(best_sad), 32'd0);
        check("rst_x", 32'(best_x), 32'd0);
        check("rst_y", 32'(best_y), 32'd0);

        // Hold across two back-to-back windows; second start lands in the first pulse cycle.
        hold_sad = 0; hold_x = 0; hold_y = 0;
        hold_on  = 1'b1;
        fill(500); vals[37] = 12;
        run_window("single", N, 1'b0, 12, 5, 2);
        fill(900); vals[3] = 7; vals[4*16+9] = 7;
        run_window("tie", N, 1'b0, 7, 3, 0);
        hold_on = 1'b0;
        for (int k = 0; k < SAD_W; k++) begin
            @(negedge clk);
            bits = {bits[SAD_W-2:0], ser_out};
        end
        check("ser_bits", 32'(bits), 32'd7);
        check("ser_hold_sad", 32'(best_sad), 32'd7);

        fill(16383);
        run_window("allmax", N, 1'b0, 16383, 0, 0);
        expect_pulse_end("allmax");

        for (int i = 0; i < N; i++) vals[i] = 1000 - i;
        run_window("ramp", N, 1'b1, 745, 15, 15);
        expect_pulse_end("ramp");

        // Abort: partial window holding a smaller value, then restart; only the second window reports.
        @(negedge clk); #1;
        p0 = pulses;
        fill(500); vals[80] = 3;
        run_window("abort_a", 100, 1'b0, 0, 0, 0);
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_keep_sad", 32'(best_sad), 32'd745);
        fill(500); vals[N-1] = 40;
        run_window("abort_b", N, 1'b0, 40, 15, 15);
        @(negedge clk); #1;
        check("abort_pulses", 32'(pulses - p0), 32'd1);

        // Asynchronous reset in mid-window clears everything at once.
        fill(50);
        run_window("mid_rst", 50, 1'b0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_res_en", 32'(res_en), 32'd0);
        check("midrst_sad", 32'(best_sad), 32'd0);
        check("midrst_x", 32'(best_x), 32'd0);
        check("midrst_y", 32'(best_y), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        p0 = pulses;
        repeat (300) @(negedge clk);
        #1;
        check("midrst_no_pulse", 32'(pulses - p0), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        fill(600); vals[200] = 9;
        run_window("post_rst", N, 1'b0, 9, 8, 12);
        expect_pulse_end("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
